lsu_controller: RTL and testbench

LSU_CONTROLLER -- requirements
Module: lsu_controller

---
 rtl/lsu_pkg.sv | 69 ++++++
 rtl/lsu_controller_load_extend.sv | 27 ++
 rtl/lsu_controller.sv | 172 +++++++++++++++++
 tb/tb_lsu_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: op encodings, FSM states,
// abort codes and lane-offset masks.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } lsu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERRC_NONE     = 2'b00,
        ERRC_MISALIGN = 2'b01,
        ERRC_TIMEOUT  = 2'b10
    } lsu_err_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    // Masks that force a byte offset onto the natural boundary of each size.
    localparam logic [1:0] LANE_MASK_BYTE = 2'b11;
    localparam logic [1:0] LANE_MASK_HALF = 2'b10;
    localparam logic [1:0] LANE_MASK_WORD = 2'b00;

    function automatic lsu_size_e op_size(input lsu_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_store(input lsu_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] lane_offset(input lsu_op_e op, input logic [1:0] lo);
        case (op_size(op))
            SZ_BYTE: return lo & LANE_MASK_BYTE;
            SZ_HALF: return lo & LANE_MASK_HALF;
            default: return lo & LANE_MASK_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input lsu_op_e op, input logic [1:0] lo);
        case (op_size(op))
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_controller_load_extend.sv
// Load result formatting: selects the addressed lane of the read word and
// sign/zero-extends it according to the load op; stores yield zero.
module load_extend
    import lsu_pkg::*;
(
    input  lsu_op_e     i_op,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_result
);

    logic [31:0] w_lane;

    always_comb begin
        w_lane   = i_rdata >> {i_offset, 3'b000};
        o_result = '0;
        case (i_op)
            OP_LB:   o_result = {{24{w_lane[7]}}, w_lane[7:0]};
            OP_LH:   o_result = {{16{w_lane[15]}}, w_lane[15:0]};
            OP_LW:   o_result = w_lane;
            OP_LBU:  o_result = {24'b0, w_lane[7:0]};
            OP_LHU:  o_result = {16'b0, w_lane[15:0]};
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Load/store unit controller: one memory access per pipeline request with timeout abort.
// Optional macro LSU_MISALIGN_TRAP_EN aborts misaligned half/word accesses instead of aligning them.
module lsu_controller
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsValid,
    input  logic [2:0]  lsCtrl,
    input  logic [31:0] lsAddr,
    input  logic [31:0] lsWdata,
    output logic        lsBusy,
    output logic        lsDone,
    output logic [31:0] lsRdata,
    output logic        lsErr,
    output logic [1:0]  lsErrCode,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    input  logic        memGnt,
    input  logic        memRvalid,
    input  logic [31:0] memRdata
);

    lsu_state_e  r_state;
    lsu_state_e  w_next;
    lsu_op_e     r_op;
    lsu_err_e    r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_cnt;
    logic        w_misalign;
    logic        w_rvalid_ok;
    logic        w_timeout;
    logic [1:0]  w_off;
    logic [31:0] w_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = misaligned(lsu_op_e'(lsCtrl), lsAddr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // Expiry is checked on the last allowed cycle so ERR follows exactly TIMEOUT_CYCLES busy cycles.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TIMEOUT_CYCLES - 32'd1);
    assign w_off     = lane_offset(r_op, r_addr[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= OP_LB;
            r_err   <= ERRC_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lsValid) begin
                        r_op    <= lsu_op_e'(lsCtrl);
                        r_addr  <= lsAddr;
                        r_wdata <= lsWdata;
                        r_cnt   <= '0;
                        r_err   <= w_misalign ? ERRC_MISALIGN : ERRC_NONE;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_rvalid_ok) begin
                        r_rdata <= memRdata;
                    end
                    if (w_next == ST_ERR) begin
                        r_err <= ERRC_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        w_rvalid_ok = 1'b0;
        lsBusy      = 1'b0;
        lsDone      = 1'b0;
        lsErr       = 1'b0;
        lsErrCode   = ERRC_NONE;
        memReq      = 1'b0;
        memWe       = 1'b0;
        memAddr     = '0;
        memBe       = '0;
        memWdata    = '0;
        case (r_state)
            ST_IDLE: begin
                if (lsValid) begin
                    w_next = w_misalign ? ST_ERR : ST_REQ;
                end
            end
            ST_REQ: begin
                lsBusy  = 1'b1;
                memReq  = 1'b1;
                memWe   = is_store(r_op);
                memAddr = {r_addr[31:2], 2'b00};
                case (op_size(r_op))
                    SZ_BYTE: begin
                        memBe    = 4'b0001 << w_off;
                        memWdata = {4{r_wdata[7:0]}};
                    end
                    SZ_HALF: begin
                        memBe    = 4'b0011 << w_off;
                        memWdata = {2{r_wdata[15:0]}};
                    end
                    default: begin
                        memBe    = 4'b1111;
                        memWdata = r_wdata;
                    end
                endcase
                if (!is_store(r_op)) begin
                    memWdata = '0;
                end
                if (memGnt) begin
                    w_rvalid_ok = memRvalid;
                    w_next      = memRvalid ? ST_DONE : ST_WAIT;
                end else if (w_timeout) begin
                    w_next = ST_ERR;
                end
            end
            ST_WAIT: begin
                lsBusy = 1'b1;
                if (memRvalid) begin
                    w_rvalid_ok = 1'b1;
                    w_next      = ST_DONE;
                end else if (w_timeout) begin
                    w_next = ST_ERR;
                end
            end
            ST_DONE: begin
                lsDone = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                lsErr     = 1'b1;
                lsErrCode = r_err;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign lsRdata = lsDone ? w_ext : '0;

    load_extend u_load_extend (
        .i_op     (r_op),
        .i_offset (w_off),
        .i_rdata  (r_rdata),
        .o_result (w_ext)
    );

endmodule

// File: tb/tb_lsu_controller.sv
// Bench for lsu_controller: transaction-level expectation timeline from the access rules,
// checked every cycle, plus literal spot checks; honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_controller;

    localparam int unsigned TO = 255;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsValid = 1'b0;
    logic [2:0]  lsCtrl = '0;
    logic [31:0] lsAddr = '0;
    logic [31:0] lsWdata = '0;
    logic        lsBusy, lsDone, lsErr, memReq, memWe;
    logic [31:0] lsRdata, memAddr, memWdata;
    logic [1:0]  lsErrCode;
    logic [3:0]  memBe;
    logic        memGnt = 1'b0;
    logic        memRvalid = 1'b0;
    logic [31:0] memRdata = '0;

    always #5 clk = ~clk;

    lsu_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .lsValid(lsValid), .lsCtrl(lsCtrl), .lsAddr(lsAddr),
        .lsWdata(lsWdata), .lsBusy(lsBusy), .lsDone(lsDone), .lsRdata(lsRdata), .lsErr(lsErr),
        .lsErrCode(lsErrCode), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memBe(memBe), .memWdata(memWdata), .memGnt(memGnt), .memRvalid(memRvalid),
        .memRdata(memRdata)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
        logic        mreq;
        logic        mwe;
        logic [31:0] maddr;
        logic [3:0]  mbe;
        logic [31:0] mwd;
    } exp_t;

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] w;
        logic        g;
        logic        rv;
        logic [31:0] rd;
    } in_t;

    typedef struct {
        logic [3:0]  be;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic [31:0] rdata;
        logic        req_end;
    } snap_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_cur = '0;
    logic exp_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("lsBusy", 32'(lsBusy), 32'(exp_cur.busy));
            chk("lsDone", 32'(lsDone), 32'(exp_cur.done));
            chk("lsRdata", lsRdata, exp_cur.rdata);
            chk("lsErr", 32'(lsErr), 32'(exp_cur.err));
            chk("lsErrCode", 32'(lsErrCode), 32'(exp_cur.code));
            chk("memReq", 32'(memReq), 32'(exp_cur.mreq));
            chk("memWe", 32'(memWe), 32'(exp_cur.mwe));
            chk("memAddr", memAddr, exp_cur.maddr);
            chk("memBe", 32'(memBe), 32'(exp_cur.mbe));
            chk("memWdata", memWdata, exp_cur.mwd);
        end
    end

    // ---- behavioural model: access rules as plain arithmetic ----
    function automatic int sz(input logic [2:0] op);
        case (op)
            3'd0, 3'd3, 3'd5: return 1;
            3'd1, 3'd4, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic int offs(input logic [2:0] op, input logic [31:0] a);
        int lo = int'(a[1:0]);
        if (sz(op) == 4) return 0;
        if (sz(op) == 2) return lo - (lo % 2);
        return lo;
    endfunction

    function automatic bit mis(input logic [2:0] op, input logic [31:0] a);
        int lo = int'(a[1:0]);
        return (sz(op) == 2 && lo % 2 != 0) || (sz(op) == 4 && lo != 0);
    endfunction

    function automatic exp_t req_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
        exp_t e = '0;
        int   s = sz(op);
        e.busy  = 1'b1;
        e.mreq  = 1'b1;
        e.mwe   = (op >= 3'd5);
        e.maddr = a - 32'(int'(a[1:0]));
        e.mbe   = 4'(((1 << s) - 1) << offs(op, a));
        if (op >= 3'd5) begin
            if (s == 1)      e.mwd = (w % 32'd256) * 32'h01010101;
            else if (s == 2) e.mwd = (w % 32'd65536) * 32'h00010001;
            else             e.mwd = w;
        end
        return e;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        int          n = 8 * sz(op);
        if (op >= 3'd5) return '0;
        v = r >> (8 * offs(op, a));
        if (n < 32) begin
            v = v & ((32'd1 << n) - 32'd1);
            if (op <= 3'd1 && v >= (32'd1 << (n - 1))) v = v - (32'd1 << n);
        end
        return v;
    endfunction

    // ---- drivers ----
    function automatic in_t noise();
        in_t i;
        i.rst_n = 1'b1;
        i.v     = 1'($urandom_range(0, 1));
        i.c     = 3'($urandom);
        i.a     = $urandom;
        i.w     = $urandom;
        i.g     = 1'($urandom_range(0, 1));
        i.rv    = 1'b0;
        i.rd    = $urandom;
        return i;
    endfunction

    task automatic cyc(input exp_t e, input in_t i);
        @(posedge clk);
        #1;
        rst_n     = i.rst_n;
        lsValid   = i.v;
        lsCtrl    = i.c;
        lsAddr    = i.a;
        lsWdata   = i.w;
        memGnt    = i.g;
        memRvalid = i.rv;
        memRdata  = i.rd;
        exp_cur   = e;
        exp_valid = 1'b1;
    endtask

    // gd: REQ cycles before the grant cycle; rd: cycles from grant to rvalid (0 = same cycle)
    task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                           input int gd, input int rd, input logic [31:0] rdat, input int gap,
                           output snap_t s);
        exp_t idle_e = '0;
        exp_t e;
        in_t  i;
        int   t = 0;
        int   gt = 0;
        bit   granted = 1'b0;
        bit   fin = 1'b0;
        bit   tmo = 1'b0;
        s = '{default: '0};
        for (int k = 0; k < gap; k++) begin
            i = noise(); i.v = 1'b0; i.rv = 1'($urandom_range(0, 1));
            cyc(idle_e, i);
        end
        i = noise(); i.v = 1'b1; i.c = op; i.a = a; i.w = w; i.rv = 1'($urandom_range(0, 1));
        cyc(idle_e, i);
        if (TRAP && mis(op, a)) begin
            e = '0; e.err = 1'b1; e.code = 2'b01;
            i = noise();
            cyc(e, i);
        end else begin
            while (!fin) begin
                t++;
                i = noise();
                if (!granted) begin
                    e    = req_exp(op, a, w);
                    i.g  = (t == gd + 1);
                    i.rv = i.g && (rd == 0);
                end else begin
                    e = '0; e.busy = 1'b1;
                    i.rv = (t == gt + rd);
                end
                if (i.rv) i.rd = rdat;
                cyc(e, i);
                if (t == 1) begin
                    #1;
                    s.be = memBe; s.we = memWe; s.addr = memAddr; s.wd = memWdata;
                end
                if (i.rv) fin = 1'b1;
                else if (!granted && i.g) begin granted = 1'b1; gt = t; end
                else if (TO != 0 && t == int'(TO)) begin fin = 1'b1; tmo = 1'b1; end
            end
            e = '0;
            if (tmo) begin e.err = 1'b1; e.code = 2'b10; end
            else begin e.done = 1'b1; e.rdata = load_val(op, a, rdat); end
            i = noise();
            cyc(e, i);
        end
        #1;
        s.done = lsDone; s.err = lsErr; s.code = lsErrCode; s.rdata = lsRdata; s.req_end = memReq;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        snap_t s;
        in_t   i;
        exp_t  e;
        for (int k = 0; k < 3; k++) begin
            i = noise(); i.rst_n = 1'b0; i.rv = 1'b1;
            cyc('0, i);
        end
        i = noise(); i.v = 1'b0;
        cyc('0, i);
        #1;
        chk("reset_memReq", 32'(memReq), 32'd0);
        chk("reset_lsBusy", 32'(lsBusy), 32'd0);

        run_txn(3'd0, 32'h0000_1003, $urandom, 0, 1, 32'h80AA5511, 1, s);
        chk("lb_1003_be", 32'(s.be), 32'h8);
        chk("lb_1003_done", 32'(s.done), 32'd1);
        chk("lb_1003_rdata", s.rdata, 32'hFFFFFF80);

        run_txn(3'd6, 32'h0000_2002, 32'h0000BEEF, 0, 0, $urandom, 0, s);
        chk("sh_2002_we", 32'(s.we), 32'd1);
        chk("sh_2002_be", 32'(s.be), 32'hC);
        chk("sh_2002_wdata", s.wd, 32'hBEEFBEEF);
        chk("sh_2002_addr", s.addr, 32'h0000_2000);
        chk("sh_2002_rdata", s.rdata, 32'd0);

        run_txn(3'd2, 32'h0000_0100, $urandom, 300, 0, $urandom, 2, s);
        chk("timeout_err", 32'(s.err), 32'd1);
        chk("timeout_code", 32'(s.code), 32'd2);
        chk("timeout_memReq", 32'(s.req_end), 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
        run_txn(3'd1, 32'h0000_3001, $urandom, 0, 0, $urandom, 1, s);
        chk("lh_3001_err", 32'(s.err), 32'd1);
        chk("lh_3001_code", 32'(s.code), 32'd1);
        chk("lh_3001_memReq", 32'(s.req_end), 32'd0);
`else
        run_txn(3'd1, 32'h0000_3001, $urandom, 0, 0, $urandom, 1, s);
        chk("lh_3001_be", 32'(s.be), 32'h3);
        run_txn(3'd4, 32'h0000_3001, $urandom, 1, 2, 32'h0000F00D, 0, s);
        chk("lhu_3001_rdata", s.rdata, 32'h0000F00D);
`endif

        // Reset while waiting for read data; the late rvalid must be ignored.
        i = noise(); i.v = 1'b1; i.c = 3'd2; i.a = 32'h0000_4000; i.g = 1'b0;
        cyc('0, i);
        i = noise(); i.g = 1'b1; i.rv = 1'b0;
        cyc(req_exp(3'd2, 32'h0000_4000, 32'd0), i);
        i = noise(); i.rst_n = 1'b0;
        e = '0; e.busy = 1'b1;
        cyc(e, i);
        i = noise(); i.v = 1'b0; i.rv = 1'b1;
        cyc('0, i);
        #1;
        chk("rst_wait_memReq", 32'(memReq), 32'd0);
        chk("rst_wait_lsBusy", 32'(lsBusy), 32'd0);
        i = noise(); i.v = 1'b0; i.rv = 1'b1;
        cyc('0, i);
        #1;
        chk("rst_wait_lsDone", 32'(lsDone), 32'd0);

        for (int n = 0; n < 150; n++) begin
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom;
            int          gd = ($urandom_range(0, 24) == 0) ? $urandom_range(250, 300) : $urandom_range(0, 4);
            int          rd = $urandom_range(0, 3);
            run_txn(op, a, $urandom, gd, rd, $urandom, $urandom_range(0, 2), s);
        end

        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
